// File: rtl/xor_unit_arbiter_pkg.sv
// Shared definitions for the XOR-cell arbiter: state encoding, default sizing
// and the bit-counter width helper.
package xor_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xor_unit_arbiter_xor_gate.sv
// Single-bit XOR cell shared by all requesters; the only XOR in the datapath.
module xorGate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter serialising NREQ W-bit XOR jobs through one xorGate cell.
// Optional parity accumulator enabled by defining XOR_ARB_PARITY_EN.
module xor_unit_arbiter
  import xor_unit_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        op_a,
  input  logic [NREQ*W-1:0]        op_b,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             result,
  output logic [$clog2(NREQ)-1:0]  result_id,
  output logic                     parity
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = cnt_w(W);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cell_y;
  logic [IDW:0]    pick;

  // Returns {found, index}: first set request at or above p, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  p);
    logic [NREQ-1:0] rot;
    logic [IDW:0]    sum;
    logic [IDW:0]    res;
    rot = NREQ'({r, r} >> p);
    res = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum = {1'b0, p} + (IDW+1)'(j);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        res = {1'b1, sum[IDW-1:0]};
      end
    end
    return res;
  endfunction

  xorGate u_xor (
    .a (sa_q[0]),
    .b (sb_q[0]),
    .y (cell_y)
  );

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[IDW]) begin
          gnt_d   = NREQ'(1) << pick[IDW-1:0];
          id_d    = pick[IDW-1:0];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < NREQ; i++) begin
          if (id_q == IDW'(i)) begin
            sa_d = op_a[i*W +: W];
            sb_d = op_b[i*W +: W];
          end
        end
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // LSB-first through the cell; W shifts leave bit 0 in result[0].
        res_d = {cell_y, res_q[W-1:1]};
        sa_d  = {1'b0, sa_q[W-1:1]};
        sb_d  = {1'b0, sb_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef XOR_ARB_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (state_q == ST_LOAD)       par_d = 1'b0;
    else if (state_q == ST_SHIFT) par_d = par_q ^ cell_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = res_q;
  assign result_id = id_q;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Randomised bench for xor_unit_arbiter against a round-robin/XOR reference model.
module tb_xor_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam logic [NREQ*W-1:0] LMASK = (NREQ*W)'({W{1'b1}});

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*W-1:0]       op_a, op_b;
  logic [NREQ-1:0]         gnt;
  logic                    busy, done, parity;
  logic [W-1:0]            result;
  logic [$clog2(NREQ)-1:0] result_id;

  int n_chk  = 0;
  int n_pass = 0;
  int mptr   = 0;

  xor_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_id (result_id),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    logic [NREQ-1:0] t;
    for (int i = 0; i < NREQ; i++) begin
      t = r >> ((p + i) % NREQ);
      if (t[0]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic exp_par(input logic [W-1:0] x);
`ifdef XOR_ARB_PARITY_EN
    return ^x;
`else
    return 1'b0 & x[0];
`endif
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a = (op_a << W) | (NREQ*W)'(W'($urandom));
      op_b = (op_b << W) | (NREQ*W)'(W'($urandom));
    end
  endtask

  // Called on the negedge of the IDLE cycle in which req is presented;
  // returns on the negedge of the following IDLE cycle.
  task automatic serve(input int id, input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input bit early, output logic [W-1:0] r_obs, output logic p_obs);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << id;
    @(negedge clk);
    chk("gnt_rise", 32'(gnt), 32'(oh));
    chk("busy_load", 32'(busy), 32'd1);
    chk("done_load", 32'(done), 32'd0);
    chk("id_load", 32'(result_id), 32'(id));
    if (early) req = req & ~oh;
    for (int k = 2; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 2) rand_ops();
      chk("gnt_hold", 32'(gnt), 32'(oh));
      chk("done_lo", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_hi", 32'(done), 32'd1);
    chk("gnt_done", 32'(gnt), 32'(oh));
    chk("result", 32'(result), 32'(ea ^ eb));
    chk("result_id", 32'(result_id), 32'(id));
    chk("parity", 32'(parity), 32'(exp_par(ea ^ eb)));
    r_obs = result;
    p_obs = parity;
    @(negedge clk);
    chk("gnt_fall", 32'(gnt), 32'd0);
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(ea ^ eb));
    mptr = (id + 1) % NREQ;
  endtask

  task automatic txn(input logic [NREQ-1:0] r, input bit early, input bit fixed,
                     input logic [W-1:0] fa, input logic [W-1:0] fb,
                     output int id, output logic [W-1:0] r_obs, output logic p_obs);
    logic [W-1:0] ea, eb;
    req = r;
    rand_ops();
    id = rr_pick(r, mptr);
    r_obs = '0;
    p_obs = 1'b0;
    if (id < 0) begin
      @(negedge clk);
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end else begin
      if (fixed) begin
        op_a = (op_a & ~(LMASK << (id * W))) | ((NREQ*W)'(fa) << (id * W));
        op_b = (op_b & ~(LMASK << (id * W))) | ((NREQ*W)'(fb) << (id * W));
      end
      ea = W'(op_a >> (id * W));
      eb = W'(op_b >> (id * W));
      serve(id, ea, eb, early, r_obs, p_obs);
    end
  endtask

  initial begin
    int           id;
    logic [W-1:0] ro;
    logic         po;
    int           seq[5];
    int           wrap[3];

    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_id", 32'(result_id), 32'd0);
    chk("rst_parity", 32'(parity), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All requesters held: strict rotation from pointer 0.
    seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 1'b0, 1'b0, '0, '0, id, ro, po);
      chk("rr_seq", 32'(id), 32'(seq[i]));
    end

    txn(4'b0001, 1'b0, 1'b1, 8'hA5, 8'h0F, id, ro, po);
    chk("single_id", 32'(id), 32'd0);
    chk("single_res", 32'(ro), 32'h0000_00AA);
    chk("single_par", 32'(po), 32'd0);

    txn(4'b0100, 1'b0, 1'b0, '0, '0, id, ro, po);
    chk("pre_wrap", 32'(id), 32'd2);
    wrap = '{3, 0, 1};
    for (int i = 0; i < 3; i++) begin
      txn(4'b1011, 1'b0, 1'b0, '0, '0, id, ro, po);
      chk("wrap_seq", 32'(id), 32'(wrap[i]));
    end

    txn(4'b0100, 1'b1, 1'b0, '0, '0, id, ro, po);
    chk("early_id", 32'(id), 32'd2);
    txn(4'b0000, 1'b0, 1'b0, '0, '0, id, ro, po);
    txn(4'b0000, 1'b0, 1'b0, '0, '0, id, ro, po);

    // Abort in the middle of SHIFT: everything returns to reset values at once.
    req  = 4'b0001;
    op_a = (op_a & ~LMASK) | (NREQ*W)'(8'hFF);
    op_b = op_b & ~LMASK;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_id", 32'(result_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    txn(4'b0010, 1'b0, 1'b0, '0, '0, id, ro, po);
    chk("post_rst_id", 32'(id), 32'd1);

    txn(4'b1000, 1'b0, 1'b1, 8'h01, 8'h00, id, ro, po);
    chk("par_res1", 32'(ro), 32'h0000_0001);
`ifdef XOR_ARB_PARITY_EN
    chk("par_one", 32'(po), 32'd1);
`else
    chk("par_tied1", 32'(po), 32'd0);
`endif
    txn(4'b0001, 1'b0, 1'b1, 8'hFF, 8'h00, id, ro, po);
    chk("par_res2", 32'(ro), 32'h0000_00FF);
    chk("par_zero", 32'(po), 32'd0);

    for (int n = 0; n < 40; n++) begin
      txn(NREQ'($urandom_range(0, (1 << NREQ) - 1)), 1'($urandom_range(0, 1)),
          1'b0, '0, '0, id, ro, po);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
